// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes the operands LSB-first,
// one bit per clock, and registers the WIDTH-bit result with carry, overflow and zero flags.

module fulladder1bit (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             s_s;
  logic             co_s;
  logic             load_s;
  logic             last_s;
  logic [WIDTH-1:0] sum_next_s;

  fulladder1bit u_fa (
    .S    (s_s),
    .Cout (co_s),
    .A    (a_sr_r[0]),
    .B    (b_sr_r[0]),
    .Cin  (carry_r)
  );

  assign load_s     = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s     = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
  assign sum_next_s = {s_s, sum_sr_r[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start in RUN is deliberately ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) state_s = RUN;
        else        state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (load_s) state_s = RUN;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      sum_sr_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      result   <= {WIDTH{1'b0}};
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (load_s) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1
      a_sr_r  <= a;
      b_sr_r  <= sub ? ~b : b;
      carry_r <= sub;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
      sum_sr_r <= sum_next_s;
      carry_r  <= co_s;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        // carry_r here is the carry into the MSB
        result   <= sum_next_s;
        cout     <= co_s;
        overflow <= co_s ^ carry_r;
        zero     <= (sum_next_s == {WIDTH{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=32 and WIDTH=4.

module tb_serial_addsub_ctrl;
  logic        clk;
  logic        rst;
  logic        start, sub;
  logic [31:0] a, b;
  logic        busy, done, cout, overflow, zero;
  logic [31:0] result;

  logic        start4, sub4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, cout4, overflow4, zero4;
  logic [3:0]  result4;

  int n_cmp;
  int n_err;

  serial_addsub_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4),
    .overflow(overflow4), .zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [31:0] er, input logic ec,
                             input logic eo, input logic ez);
    chk({tag, ".result"}, result, er);
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
  endtask

  // Launch an op, count edges from the sampling edge until done (bounded), check results
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [31:0] er, input logic ec,
                        input logic eo, input logic ez);
    int n;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done) chk({tag, ".busy_run"}, 32'(busy), 32'd1);
    end
    chk({tag, ".latency"}, 32'(n), 32'd32);
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    check_flags(tag, er, ec, eo, ez);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 32'd0; b = 32'd0;
    start4 = 1'b0; sub4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    check_flags("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("add5_3",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_op("sub5_5",  32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub3_5",  32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // start and operand changes mid-run are ignored: 10+20 still yields 30, one done only
    @(negedge clk);
    a = 32'd10; b = 32'd20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    a = 32'd100; b = 32'd1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 10;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign.latency", 32'(n), 32'd32);
    check_flags("ign", 32'd30, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("ign.extra_done", 32'(pulses), 32'd0);

    // start held high through DONE launches a second op that samples its operands there
    @(negedge clk);
    a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd7; b = 32'd8;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b.lat1", 32'(n), 32'd32);
    check_flags("b2b1", 32'd3, 1'b0, 1'b0, 1'b0);
    n = 0;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    chk("b2b.restart_busy", 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b.gap", 32'(n), 32'd33);
    check_flags("b2b2", 32'd15, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run clears everything immediately, no done follows
    @(negedge clk);
    a = 32'd9; b = 32'd9; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.done", 32'(done), 32'd0);
    check_flags("mid_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("mid_rst.quiet", 32'(pulses), 32'd0);
    run_op("post_rst", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

    // Narrow instance: 7+1 at WIDTH=4 overflows into 0x8
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h1; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4.latency", 32'(n), 32'd4);
    chk("w4.result", 32'(result4), 32'h8);
    chk("w4.ovf", 32'(overflow4), 32'd1);
    chk("w4.cout", 32'(cout4), 32'd0);
    chk("w4.zero", 32'(zero4), 32'd0);

    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; sub4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4s.latency", 32'(n), 32'd4);
    chk("w4s.result", 32'(result4), 32'hE);
    chk("w4s.cout", 32'(cout4), 32'd0);
    chk("w4s.ovf", 32'(overflow4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
